// File: rtl/fp_serial_tx_if.sv
// Word handshake between the float converter and fp_serial_tx.
// Carries one {S, E, F} word per in_valid && in_ready edge.
interface fp_serial_tx_if;
   logic       in_valid;
   logic       in_ready;
   logic       S;
   logic [2:0] E;
   logic [4:0] F;

   modport master (
      output in_valid, S, E, F,
      input  in_ready
   );

   modport slave (
      input  in_valid, S, E, F,
      output in_ready
   );
endinterface

// File: rtl/fp_serial_tx.sv
// FIFO-buffered UART-style transmitter for 8-bit floats {S,E,F}, LSB first.
// Define FP_TX_PARITY_EN to append an even parity bit to each frame.
module fp_serial_tx #(
   parameter  int CLKS_PER_BIT = 4,
   parameter  int FIFO_DEPTH   = 4,
   localparam int PW           = $clog2(FIFO_DEPTH),
   localparam int CW           = PW + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   fp_serial_tx_if.slave  in_if,
   output logic           tx,
   output logic           busy,
   output logic [CW-1:0]  fifo_count
);

`ifdef FP_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   state_e        state_q, state_d;
   logic [7:0]    cell_q, cell_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
`ifdef FP_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   logic          push;
   logic          pop;
   logic          fifo_empty;
   logic          cell_end;
   logic [7:0]    head;

   assign in_if.in_ready = (count_q != CW'(FIFO_DEPTH));
   assign push       = in_if.in_valid && in_if.in_ready;
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign cell_end   = (cell_q == 8'(CLKS_PER_BIT - 1));

   assign tx         = tx_q;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign fifo_count = count_q;

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cell_d  = cell_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef FP_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
`ifdef FP_TX_PARITY_EN
               par_d   = ^head;
`endif
               tx_d    = 1'b0;
               cell_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (cell_end) begin
               cell_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cell_d = cell_q + 8'd1;
            end
         end
         DATA: begin
            if (cell_end) begin
               cell_d = '0;
               if (bit_q == 3'd7) begin
`ifdef FP_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end else begin
               cell_d = cell_q + 8'd1;
            end
         end
`ifdef FP_TX_PARITY_EN
         PARITY: begin
            if (cell_end) begin
               cell_d  = '0;
               tx_d    = 1'b1;
               state_d = STOP;
            end else begin
               cell_d = cell_q + 8'd1;
            end
         end
`endif
         STOP: begin
            if (cell_end) begin
               cell_d = '0;
               // Chain straight into the next start bit when data waits.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
`ifdef FP_TX_PARITY_EN
                  par_d   = ^head;
`endif
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cell_d = cell_q + 8'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= {in_if.S, in_if.E, in_if.F};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         cell_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef FP_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         cell_q   <= cell_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef FP_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

endmodule
